// File: rtl/var_latency_mul_if.sv
// Valid/ready bundle for var_latency_mul: operand request side and product response side.
interface var_latency_mul_if #(
   parameter int WIDTH = 8
);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] product;
   logic               narrow;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, product, narrow
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, product, narrow
   );
endinterface

// File: rtl/var_latency_mul.sv
// Radix-2^DIGIT shift-add unsigned multiplier; stops as soon as the remaining
// multiplier digits are zero, so latency tracks the bit length of min(a,b).
module var_latency_mul #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   var_latency_mul_if.slave     bus
);
   localparam int HALF = WIDTH / 2;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t             r_state;
   logic [WIDTH-1:0]   r_mlt;
   logic [2*WIDTH-1:0] r_mcd;
   logic [2*WIDTH-1:0] r_acc;
   logic               r_narrow;

   logic               w_a_lt_b;
   logic [WIDTH-1:0]   w_mlt_in;
   logic [WIDTH-1:0]   w_mcd_in;
   logic [WIDTH-1:0]   w_mlt_nxt;
   logic [2*WIDTH-1:0] w_pp;

   function automatic logic fits_half(input logic [WIDTH-1:0] v);
      return (v >> HALF) == '0;
   endfunction

   // Smaller operand becomes the multiplier so the loop runs the fewest digits.
   assign w_a_lt_b  = bus.a < bus.b;
   assign w_mlt_in  = w_a_lt_b ? bus.a : bus.b;
   assign w_mcd_in  = w_a_lt_b ? bus.b : bus.a;
   assign w_mlt_nxt = r_mlt >> DIGIT;
   assign w_pp      = r_mcd * {{(2*WIDTH-DIGIT){1'b0}}, r_mlt[DIGIT-1:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_mlt    <= '0;
         r_mcd    <= '0;
         r_acc    <= '0;
         r_narrow <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_mlt    <= w_mlt_in;
                  r_mcd    <= {{WIDTH{1'b0}}, w_mcd_in};
                  r_acc    <= '0;
                  r_narrow <= fits_half(bus.a) && fits_half(bus.b);
                  r_state  <= (w_mlt_in == '0) ? S_DONE : S_RUN;
               end
            end
            S_RUN: begin
               r_acc <= r_acc + w_pp;
               r_mcd <= r_mcd << DIGIT;
               r_mlt <= w_mlt_nxt;
               if (w_mlt_nxt == '0) r_state <= S_DONE;
            end
            S_DONE: begin
               if (bus.out_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (r_state == S_IDLE);
   assign bus.out_valid = (r_state == S_DONE);
   assign bus.product   = r_acc;
   assign bus.narrow    = r_narrow;
endmodule

// File: tb/tb_var_latency_mul.sv
// Bench for var_latency_mul: directed table at 8/2, handshake and reset corner
// sequences, then random sweeps at 16/4 and 8/1 against a scoreboard.
module tb_var_latency_mul;
   typedef struct {
      logic [31:0] prod;
      logic        nar;
      int          lat;
   } exp_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] prod;
      logic        nar;
      int          lat;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   int          sel = 0;
   logic        d_valid = 1'b0;
   logic        d_oready = 1'b1;
   logic [15:0] d_a = '0;
   logic [15:0] d_b = '0;
   logic        m_in_ready, m_out_valid, m_narrow;
   logic [31:0] m_product;

   int   n_pass = 0;
   int   n_total = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   var_latency_mul_if #(.WIDTH(8))  if0 ();
   var_latency_mul_if #(.WIDTH(16)) if1 ();
   var_latency_mul_if #(.WIDTH(8))  if2 ();

   var_latency_mul #(.WIDTH(8),  .DIGIT(2)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
   var_latency_mul #(.WIDTH(16), .DIGIT(4)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
   var_latency_mul #(.WIDTH(8),  .DIGIT(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

   assign if0.in_valid  = d_valid && (sel == 0);
   assign if1.in_valid  = d_valid && (sel == 1);
   assign if2.in_valid  = d_valid && (sel == 2);
   assign if0.out_ready = d_oready;
   assign if1.out_ready = d_oready;
   assign if2.out_ready = d_oready;
   assign if0.a = d_a[7:0];
   assign if0.b = d_b[7:0];
   assign if1.a = d_a;
   assign if1.b = d_b;
   assign if2.a = d_a[7:0];
   assign if2.b = d_b[7:0];

   always_comb begin
      m_in_ready  = if0.in_ready;
      m_out_valid = if0.out_valid;
      m_product   = {16'h0, if0.product};
      m_narrow    = if0.narrow;
      if (sel == 1) begin
         m_in_ready  = if1.in_ready;
         m_out_valid = if1.out_valid;
         m_product   = if1.product;
         m_narrow    = if1.narrow;
      end else if (sel == 2) begin
         m_in_ready  = if2.in_ready;
         m_out_valid = if2.out_valid;
         m_product   = {16'h0, if2.product};
         m_narrow    = if2.narrow;
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (time %0t)", name, got, exp, $time);
   endtask

   // Drives one operation; hold>0 keeps out_ready low that many cycles after
   // out_valid rises while a competing request sits on the input.
   task automatic op(input logic [15:0] a, input logic [15:0] b, input exp_t e,
                     input int hold, output int lat, output int lowcnt);
      exp_t x;
      @(negedge clk);
      chk("accept_in_ready", {31'b0, m_in_ready}, 32'd1);
      d_a = a; d_b = b; d_valid = 1'b1; d_oready = (hold == 0);
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      d_valid = 1'b0;
      lat = 1;
      lowcnt = 0;
      while (!m_out_valid && lat < 100) begin
         if (!m_in_ready) lowcnt++;
         @(negedge clk);
         lat++;
      end
      if (!m_in_ready) lowcnt++;
      x = sb.pop_front();
      chk("product", m_product, x.prod);
      chk("narrow", {31'b0, m_narrow}, {31'b0, x.nar});
      chk("latency", lat, x.lat);
      for (int i = 0; i < hold; i++) begin
         d_a = 16'd1; d_b = 16'd1; d_valid = 1'b1;
         @(negedge clk);
         if (!m_in_ready) lowcnt++;
         chk("hold_out_valid", {31'b0, m_out_valid}, 32'd1);
         chk("hold_in_ready", {31'b0, m_in_ready}, 32'd0);
         chk("hold_product", m_product, x.prod);
      end
      d_oready = 1'b1;
      @(negedge clk);
      d_valid = 1'b0;
      chk("post_in_ready", {31'b0, m_in_ready}, 32'd1);
      chk("post_out_valid", {31'b0, m_out_valid}, 32'd0);
   endtask

   function automatic int ref_lat(input logic [15:0] a, input logic [15:0] b, input int digit);
      logic [15:0] m;
      int bl;
      m = (a < b) ? a : b;
      bl = 0;
      for (int i = 0; i < 16; i++) if (m[i]) bl = i + 1;
      return (bl + digit - 1) / digit + 1;
   endfunction

   task automatic sweep(input int s, input int width, input int digit);
      logic [15:0] a, b, lim;
      exp_t e;
      int lat, lowcnt;
      sel = s;
      lim = 16'((32'd1 << (width / 2)));
      for (int i = 0; i < 1000; i++) begin
         a = 16'($urandom_range(0, 65535) >> $urandom_range(0, 16));
         b = 16'($urandom_range(0, 65535) >> $urandom_range(0, 16));
         if (width == 8) begin
            a = a & 16'h00FF;
            b = b & 16'h00FF;
         end
         e.prod = {16'h0, a} * {16'h0, b};
         e.nar  = (a < lim) && (b < lim);
         e.lat  = ref_lat(a, b, digit);
         op(a, b, e, 0, lat, lowcnt);
      end
   endtask

   vec_t vecs[9];

   initial begin
      int   lat, lowcnt;
      exp_t e;

      vecs[0] = '{a: 3,   b: 5,   prod: 15,    nar: 1'b1, lat: 2};
      vecs[1] = '{a: 200, b: 0,   prod: 0,     nar: 1'b0, lat: 1};
      vecs[2] = '{a: 255, b: 255, prod: 65025, nar: 1'b0, lat: 5};
      vecs[3] = '{a: 2,   b: 250, prod: 500,   nar: 1'b0, lat: 2};
      vecs[4] = '{a: 250, b: 2,   prod: 500,   nar: 1'b0, lat: 2};
      vecs[5] = '{a: 0,   b: 0,   prod: 0,     nar: 1'b1, lat: 1};
      vecs[6] = '{a: 15,  b: 15,  prod: 225,   nar: 1'b1, lat: 3};
      vecs[7] = '{a: 16,  b: 16,  prod: 256,   nar: 1'b0, lat: 4};
      vecs[8] = '{a: 128, b: 13,  prod: 1664,  nar: 1'b0, lat: 3};

      // Reset is checked before any clock edge, so it must act asynchronously.
      #2 rst_n = 1'b0;
      #1;
      chk("reset_in_ready", {31'b0, m_in_ready}, 32'd1);
      chk("reset_out_valid", {31'b0, m_out_valid}, 32'd0);
      chk("reset_product", m_product, 32'd0);
      chk("reset_narrow", {31'b0, m_narrow}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         e.prod = vecs[i].prod;
         e.nar  = vecs[i].nar;
         e.lat  = vecs[i].lat;
         op(vecs[i].a, vecs[i].b, e, 0, lat, lowcnt);
         chk("in_ready_low_cycles", lowcnt, vecs[i].lat);
      end

      e = '{prod: 63, nar: 1'b1, lat: 3};
      op(16'd7, 16'd9, e, 6, lat, lowcnt);
      chk("bp_in_ready_low_cycles", lowcnt, 9);

      // Reset two cycles into a long run.
      @(negedge clk);
      d_a = 16'd255; d_b = 16'd255; d_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      d_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midrun_out_valid", {31'b0, m_out_valid}, 32'd0);
      chk("midrun_in_ready", {31'b0, m_in_ready}, 32'd1);
      chk("midrun_product", m_product, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset while a result is waiting: out_valid must drop mid-cycle.
      @(negedge clk);
      d_a = 16'd3; d_b = 16'd5; d_valid = 1'b1; d_oready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      d_valid = 1'b0;
      @(negedge clk);
      chk("done_out_valid", {31'b0, m_out_valid}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("done_reset_out_valid", {31'b0, m_out_valid}, 32'd0);
      chk("done_reset_product", m_product, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      d_oready = 1'b1;
      sb.delete();

      e = '{prod: 16, nar: 1'b1, lat: 3};
      op(16'd4, 16'd4, e, 0, lat, lowcnt);

      sweep(1, 16, 4);
      sweep(2, 8, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
